// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric unit: per-hypothesis lane distances summed into
// CODE_N-lane metrics, registered in two valid/ready stages with a minimum picker.
module bmc_soft_pipe #(
   parameter int  CODE_N = 2,
   parameter int  Q      = 3,
   localparam int MW     = Q + $clog2(CODE_N),
   localparam int NH     = 2 ** CODE_N
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CODE_N*Q-1:0] rx_sym,
   input  logic [CODE_N-1:0]   erase,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NH*MW-1:0]    out_metrics,
   output logic [CODE_N-1:0]   out_min_idx,
   output logic                out_last,
   output logic [15:0]         sym_cnt
);
   localparam logic [Q-1:0] SMAX = {Q{1'b1}};

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // the whole pipe advances together whenever the output slot is empty or being taken.
   logic                w_advance;
   logic                w_accept;
   logic [CODE_N*Q-1:0] w_d0;
   logic [CODE_N*Q-1:0] w_d1;
   logic [NH*MW-1:0]    w_metrics;
   logic [CODE_N-1:0]   w_min_idx;

   logic                r_s1_valid;
   logic [CODE_N*Q-1:0] r_s1_d0;
   logic [CODE_N*Q-1:0] r_s1_d1;
   logic                r_s1_last;
   logic                r_s2_valid;
   logic [NH*MW-1:0]    r_s2_metrics;
   logic [CODE_N-1:0]   r_s2_min_idx;
   logic                r_s2_last;
   logic [15:0]         r_sym_cnt;

   assign w_advance = !r_s2_valid || out_ready;
   assign in_ready  = w_advance || rst;
   assign w_accept  = in_valid && w_advance && !rst;

   // Distance to an expected 0 and to an expected 1 for every lane; punctured lanes cost nothing.
   always_comb begin
      w_d0 = '0;
      w_d1 = '0;
      for (int i = 0; i < CODE_N; i++) begin
         if (!erase[i]) begin
            w_d0[i*Q +: Q] = rx_sym[i*Q +: Q];
            w_d1[i*Q +: Q] = SMAX - rx_sym[i*Q +: Q];
         end
      end
   end

   always_comb begin
      logic [MW-1:0] v_sum;
      logic [MW-1:0] v_best;
      v_sum     = '0;
      v_best    = '0;
      w_metrics = '0;
      w_min_idx = '0;
      for (int h = 0; h < NH; h++) begin
         v_sum = '0;
         for (int i = 0; i < CODE_N; i++) begin
            if (((h >> i) & 1) != 0)
               v_sum = v_sum + MW'(r_s1_d1[i*Q +: Q]);
            else
               v_sum = v_sum + MW'(r_s1_d0[i*Q +: Q]);
         end
         w_metrics[h*MW +: MW] = v_sum;
         // Strict compare keeps the lowest index on ties.
         if (h == 0 || v_sum < v_best) begin
            v_best    = v_sum;
            w_min_idx = CODE_N'(h);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_d0      <= '0;
         r_s1_d1      <= '0;
         r_s1_last    <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_metrics <= '0;
         r_s2_min_idx <= '0;
         r_s2_last    <= 1'b0;
         r_sym_cnt    <= '0;
      end else begin
         if (w_advance) begin
            r_s1_valid   <= in_valid;
            r_s1_d0      <= w_d0;
            r_s1_d1      <= w_d1;
            r_s1_last    <= in_last;
            r_s2_valid   <= r_s1_valid;
            r_s2_metrics <= w_metrics;
            r_s2_min_idx <= w_min_idx;
            r_s2_last    <= r_s1_last;
         end
         if (w_accept)
            r_sym_cnt <= in_last ? 16'd0 : r_sym_cnt + 16'd1;
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_metrics = r_s2_metrics;
   assign out_min_idx = r_s2_min_idx;
   assign out_last    = r_s2_last;
   assign sym_cnt     = r_sym_cnt;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: directed steps, scoreboard of expected bundles fed on
// acceptance and drained on output transfer, plus a Q=1 instance for hard decisions.
module tb_bmc_soft_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  rx_sym;
   logic [1:0]  erase;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_metrics;
   logic [1:0]  out_min_idx;
   logic        out_last;
   logic [15:0] sym_cnt;

   logic        q1_in_valid;
   logic        q1_in_ready;
   logic [1:0]  q1_rx_sym;
   logic        q1_out_valid;
   logic [7:0]  q1_out_metrics;
   logic [1:0]  q1_out_min_idx;
   logic        q1_out_last;
   logic [15:0] q1_sym_cnt;

   logic [18:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;

   always #5 clk = ~clk;

   bmc_soft_pipe #(.CODE_N(2), .Q(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rx_sym(rx_sym), .erase(erase), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_metrics(out_metrics),
      .out_min_idx(out_min_idx), .out_last(out_last), .sym_cnt(sym_cnt)
   );

   bmc_soft_pipe #(.CODE_N(2), .Q(1)) dut_q1 (
      .clk(clk), .rst(rst), .in_valid(q1_in_valid), .in_ready(q1_in_ready),
      .rx_sym(q1_rx_sym), .erase(2'b00), .in_last(1'b0),
      .out_valid(q1_out_valid), .out_ready(1'b1), .out_metrics(q1_out_metrics),
      .out_min_idx(q1_out_min_idx), .out_last(q1_out_last), .sym_cnt(q1_sym_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference: lane distance is s for an expected 0, 7-s for an expected 1, 0 if erased.
   function automatic logic [18:0] model(input logic [5:0] rx, input logic [1:0] er,
                                         input logic last);
      int m[4];
      int s;
      int best;
      int bi;
      for (int h = 0; h < 4; h++) begin
         m[h] = 0;
         for (int i = 0; i < 2; i++) begin
            s = int'(rx[i*3 +: 3]);
            if (!er[i]) m[h] += (((h >> i) & 1) != 0) ? (7 - s) : s;
         end
      end
      best = m[0];
      bi   = 0;
      for (int h = 1; h < 4; h++) begin
         if (m[h] < best) begin
            best = m[h];
            bi   = h;
         end
      end
      return {last, 2'(bi), 4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0])};
   endfunction

   task automatic monitor();
      logic [18:0] exp_v;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
         end else begin
            if (in_valid && in_ready) exp_q.push_back(model(rx_sym, erase, in_last));
            if (out_valid && out_ready) begin
               n_out++;
               check("sb_nonempty", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  exp_v = exp_q.pop_front();
                  check("sb_out", {13'd0, out_last, out_min_idx, out_metrics}, {13'd0, exp_v});
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] l0, input logic [2:0] l1, input logic [1:0] er,
                       input logic last);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      rx_sym   = {l1, l0};
      erase    = er;
      in_last  = last;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      check("send_accept", 32'(acc), 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   logic [2:0]  st_l0[6] = '{3'd1, 3'd6, 3'd0, 3'd7, 3'd4, 3'd2};
   logic [2:0]  st_l1[6] = '{3'd5, 3'd2, 3'd7, 3'd3, 3'd4, 3'd0};
   logic [15:0] held_metrics;
   int          idx;
   int          out_base;

   initial begin
      rst = 1'b1; in_valid = 1'b0; rx_sym = '0; erase = '0; in_last = 1'b0; out_ready = 1'b1;
      q1_in_valid = 1'b0; q1_rx_sym = '0;
      held_metrics = '0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) tick();
      in_valid = 1'b1; rx_sym = 6'o77;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_metrics", 32'(out_metrics), 0);
      check("rst_min_idx", 32'(out_min_idx), 0);
      check("rst_last", 32'(out_last), 0);
      check("rst_sym_cnt", 32'(sym_cnt), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_no_accept", 32'(sym_cnt), 0);
      tick();

      // Frame of 5 with in_last on the fifth
      send(3'd1, 3'd2, 2'b00, 1'b0); check("cnt_1", 32'(sym_cnt), 1);
      send(3'd3, 3'd4, 2'b00, 1'b0); check("cnt_2", 32'(sym_cnt), 2);
      send(3'd5, 3'd6, 2'b00, 1'b0); check("cnt_3", 32'(sym_cnt), 3);
      send(3'd7, 3'd0, 2'b00, 1'b0); check("cnt_4", 32'(sym_cnt), 4);
      send(3'd0, 3'd7, 2'b00, 1'b1); check("cnt_last", 32'(sym_cnt), 0);
      repeat (3) tick();
      check("frame_outs", 32'(n_out), 5);

      // Lanes (7,0): latency 2 and fixed metrics
      send(3'd7, 3'd0, 2'b00, 1'b0);
      in_last = 1'b1;
      @(negedge clk);
      check("lat_s1_not_out", 32'(out_valid), 0);
      tick();
      @(negedge clk);
      check("lat_out_valid", 32'(out_valid), 1);
      check("m70_metrics", 32'(out_metrics), {16'd0, 4'd7, 4'd14, 4'd0, 4'd7});
      check("m70_min_idx", 32'(out_min_idx), 1);
      tick();
      check("idle_last_no_cnt", 32'(sym_cnt), 1);
      in_last = 1'b0;

      // Lanes (2,5), lane1 punctured: tie resolves low
      send(3'd2, 3'd5, 2'b10, 1'b0);
      @(negedge clk);
      tick();
      @(negedge clk);
      check("er_metrics", 32'(out_metrics), {16'd0, 4'd5, 4'd2, 4'd5, 4'd2});
      check("er_min_idx", 32'(out_min_idx), 0);
      check("cnt_after_er", 32'(sym_cnt), 2);

      // Hard-decision build, lanes (1,1)
      q1_in_valid = 1'b1; q1_rx_sym = 2'b11;
      tick();
      q1_in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("q1_out_valid", 32'(q1_out_valid), 1);
      check("q1_metrics", 32'(q1_out_metrics), {24'd0, 2'd0, 2'd1, 2'd1, 2'd2});
      check("q1_min_idx", 32'(q1_out_min_idx), 3);
      check("q1_last", 32'(q1_out_last), 0);
      check("q1_sym_cnt", 32'(q1_sym_cnt), 1);
      check("q1_in_ready", 32'(q1_in_ready), 1);
      repeat (3) tick();

      // Back-to-back stream of 6 with out_ready low on cycles 3-4
      out_base = n_out;
      idx = 0;
      for (int c = 0; c < 16 && idx < 6; c++) begin
         out_ready = !(c == 3 || c == 4);
         in_valid  = 1'b1;
         rx_sym    = {st_l1[idx], st_l0[idx]};
         erase     = 2'b00;
         @(negedge clk);
         check("stream_in_ready", 32'(in_ready), (c == 3 || c == 4) ? 0 : 1);
         if (c == 3) begin
            check("stall_valid", 32'(out_valid), 1);
            held_metrics = out_metrics;
         end
         if (c == 4) check("stall_hold", 32'(out_metrics), 32'(held_metrics));
         if (in_ready) idx++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("stream_outs", 32'(n_out - out_base), 6);
      check("stream_cnt", 32'(sym_cnt), 8);

      // Reset with two symbols in flight
      out_base  = n_out;
      out_ready = 1'b0;
      send(3'd1, 3'd1, 2'b00, 1'b0);
      send(3'd3, 3'd3, 2'b00, 1'b0);
      rst = 1'b1;
      in_valid = 1'b1; rx_sym = {3'd5, 3'd5};
      @(negedge clk);
      tick();
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 0);
      check("flush_sym_cnt", 32'(sym_cnt), 0);
      check("flush_in_ready", 32'(in_ready), 1);
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_cnt", 32'(sym_cnt), 0);
      for (int k = 0; k < 3; k++) begin
         check("no_ghost", 32'(out_valid), 0);
         tick();
         @(negedge clk);
      end
      tick();
      send(3'd6, 3'd2, 2'b00, 1'b1);
      repeat (4) tick();
      check("post_rst_outs", 32'(n_out - out_base), 1);

      check("sb_drained", 32'(exp_q.size()), 0);
      check("total_outs", 32'(n_out), 14);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
